second_operand_handler: RTL and testbench
=========================================

SECOND_OPERAND_HANDLER -- requirements
Module: second_operand_handler

Interface
- REQ-001: The block SHALL use one clock and an asynchronous, active-low reset, with ports named clk and rst_n.
- REQ-002: Port clk, input, 1 bit: rising-edge clock.
- REQ-003: Port rst_n, input, 1 bit: asynchronous active-low reset.
- REQ-004: Port in_valid, input, 1 bit: the operand inputs are valid this cycle.
- REQ-005: Port Si, input, 3 bits: operand source select.
- REQ-006: Port PB, input, 32 bits: register-file port B value.
- REQ-007: Port imm12_I, input, 12 bits: I-type immediate.
- REQ-008: Port imm12_S, input, 12 bits: S-type immediate.
- REQ-009: Port PC, input, 32 bits: program counter.
- REQ-010: Port imm20, input, 20 bits: U-type immediate.
- REQ-011: Port N, output, 32 bits: registered second operand.
- REQ-012: Port out_valid, output, 1 bit: N holds a newly captured result.

Function
- REQ-013: The select SHALL be decoded combinationally as follows:
  - 000: N = PB.
  - 001: N = sign-extended imm12_I.
  - 010: N = sign-extended imm12_S.
  - 011: N = {imm20, 12'h000}.
  - 100: N = PC.
  - 101: N = {27'b0, imm12_I[4:0]}, the shift amount.
  - 110: N = PC + {imm20, 12'h000}, per REQ-022.
  - 111: N = 32'h0000_0000.
- REQ-014: The decoded value SHALL be registered into N on the rising clk edge when in_valid=1, giving a latency of exactly 1 cycle.
- REQ-015: When in_valid=0, N SHALL hold its previous value.
- REQ-016: out_valid SHALL equal in_valid delayed by one cycle.
- REQ-017: All arithmetic SHALL be 32-bit modulo 2^32; carry-out is discarded and there is no overflow flag.
- REQ-018: Sign extension SHALL replicate bit 11 of the selected immediate into bits 31:12.
- REQ-019: Back-to-back in_valid pulses with changing Si SHALL produce a new result every cycle with no bubbles.

Reset
- REQ-020: While rst_n=0, N SHALL be 32'h0 and out_valid SHALL be 0, taking effect immediately (asynchronous).
- REQ-021: On reset release, the first capture SHALL occur at the first rising edge at which in_valid=1; a reset asserted mid-stream SHALL discard the pending result.

Configuration
- REQ-022: Macro SOH_AUIPC_EN:
  - When defined, Si=110 SHALL produce PC + {imm20, 12'h000}.
  - When undefined, Si=110 SHALL produce 32'h0 and no adder SHALL be synthesized.
  - All other encodings SHALL be unaffected by the macro.

Structure
- REQ-023: A shared package soh_pkg SHALL hold the 3-bit select encoding constants (SEL_PB, SEL_IMM_I, SEL_IMM_S, SEL_UPPER, SEL_PC, SEL_SHAMT, SEL_AUIPC, SEL_ZERO) and the 32-bit operand typedef.
- REQ-024: A combinational sub-module soh_imm_ext SHALL generate the I, S, U and shamt expansions; the top level SHALL contain the select mux and the output register.

Verification
Common stimulus values: PB=0x0431FFEA, PC=0xC431FFEA, imm12_I=0xC0C, imm12_S=0x70F, imm20=0xEC44F, in_valid=1.
- REQ-025: Sweep Si=000..111 with the common values; N one cycle later SHALL be, in order:
  - 0x0431FFEA
  - 0xFFFFFC0C
  - 0x0000070F
  - 0xEC44F000
  - 0xC431FFEA
  - 0x0000000C
  - 0xB076EFEA (0x00000000 without SOH_AUIPC_EN)
  - 0x00000000
- REQ-026: Sign-extension boundary: imm12_I=0x800 with Si=001 SHALL give N=0xFFFFF800; imm12_I=0x7FF with Si=001 SHALL give N=0x000007FF.
- REQ-027: Hold: capture Si=000, then drop in_valid and change PB; N SHALL stay 0x0431FFEA and out_valid SHALL be 0.
- REQ-028: Reset mid-stream: assert rst_n=0 between clock edges; N SHALL read 0x0 and out_valid 0 immediately, and both SHALL remain there until the first capture after release.
- REQ-029: Wrap-around: PC=0xFFFFF000, imm20=0x00001, Si=110 (SOH_AUIPC_EN defined) SHALL give N=0x00000000.

Source files
------------

// File: rtl/soh_pkg.sv
// rtl/soh_pkg.sv - shared select encodings and operand type for the second operand handler
package soh_pkg;

    typedef logic [31:0] operand_t;
    typedef logic [2:0]  sel_t;

    localparam sel_t SEL_PB    = 3'b000;
    localparam sel_t SEL_IMM_I = 3'b001;
    localparam sel_t SEL_IMM_S = 3'b010;
    localparam sel_t SEL_UPPER = 3'b011;
    localparam sel_t SEL_PC    = 3'b100;
    localparam sel_t SEL_SHAMT = 3'b101;
    localparam sel_t SEL_AUIPC = 3'b110;
    localparam sel_t SEL_ZERO  = 3'b111;

    function automatic operand_t sext12(input logic [11:0] imm);
        return {{20{imm[11]}}, imm};
    endfunction

endpackage

// File: rtl/soh_imm_ext.sv
// rtl/soh_imm_ext.sv - combinational I/S/U immediate and shift-amount expansion
module soh_imm_ext
    import soh_pkg::*;
(
    input  logic [11:0] imm12_I,
    input  logic [11:0] imm12_S,
    input  logic [19:0] imm20,
    output operand_t    imm_i,
    output operand_t    imm_s,
    output operand_t    imm_u,
    output operand_t    shamt
);

    assign imm_i = sext12(imm12_I);
    assign imm_s = sext12(imm12_S);
    assign imm_u = {imm20, 12'h000};
    // Shift amount reuses the low five bits of the I-type immediate field.
    assign shamt = {27'b0, imm12_I[4:0]};

endmodule

// File: rtl/second_operand_handler.sv
// rtl/second_operand_handler.sv - select mux and output register; SOH_AUIPC_EN enables PC+upper on Si=110
module second_operand_handler
    import soh_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [2:0]  Si,
    input  logic [31:0] PB,
    input  logic [11:0] imm12_I,
    input  logic [11:0] imm12_S,
    input  logic [31:0] PC,
    input  logic [19:0] imm20,
    output logic [31:0] N,
    output logic        out_valid
);

    operand_t imm_i;
    operand_t imm_s;
    operand_t imm_u;
    operand_t shamt;
    operand_t auipc;
    operand_t next_n;

    soh_imm_ext u_imm_ext (
        .imm12_I (imm12_I),
        .imm12_S (imm12_S),
        .imm20   (imm20),
        .imm_i   (imm_i),
        .imm_s   (imm_s),
        .imm_u   (imm_u),
        .shamt   (shamt)
    );

`ifdef SOH_AUIPC_EN
    assign auipc = PC + imm_u;
`else
    assign auipc = '0;
`endif

    always_comb begin
        next_n = '0;
        case (Si)
            SEL_PB:    next_n = PB;
            SEL_IMM_I: next_n = imm_i;
            SEL_IMM_S: next_n = imm_s;
            SEL_UPPER: next_n = imm_u;
            SEL_PC:    next_n = PC;
            SEL_SHAMT: next_n = shamt;
            SEL_AUIPC: next_n = auipc;
            SEL_ZERO:  next_n = '0;
        endcase
    end

    // N only moves on a valid beat; out_valid is in_valid delayed one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            N         <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                N <= next_n;
            end
        end
    end

endmodule

// File: tb/tb_second_operand_handler.sv
// tb/tb_second_operand_handler.sv - scoreboard bench for second_operand_handler
module tb_second_operand_handler;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [2:0]  Si;
    logic [31:0] PB;
    logic [11:0] imm12_I;
    logic [11:0] imm12_S;
    logic [31:0] PC;
    logic [19:0] imm20;
    logic [31:0] N;
    logic        out_valid;

    second_operand_handler dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .Si        (Si),
        .PB        (PB),
        .imm12_I   (imm12_I),
        .imm12_S   (imm12_S),
        .PC        (PC),
        .imm20     (imm20),
        .N         (N),
        .out_valid (out_valid)
    );

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    logic [31:0] hold_val;
    int          cyc;
    int          tests;
    int          fails;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] si, input logic [31:0] pb,
                                          input logic [31:0] pc, input logic [11:0] ii,
                                          input logic [11:0] is, input logic [19:0] u);
        logic [31:0] upper;
        upper = 32'(u) * 32'd4096;
        case (si)
            3'd0: return pb;
            3'd1: return 32'($signed(ii));
            3'd2: return 32'($signed(is));
            3'd3: return upper;
            3'd4: return pc;
            3'd5: return 32'(ii % 12'd32);
`ifdef SOH_AUIPC_EN
            3'd6: return pc + upper;
`else
            3'd6: return 32'd0;
`endif
            default: return 32'd0;
        endcase
    endfunction

    task automatic drive(input logic v, input logic [2:0] si, input logic [31:0] pb,
                         input logic [31:0] pc, input logic [11:0] ii, input logic [11:0] is,
                         input logic [19:0] u, input logic [31:0] expv);
        @(posedge clk);
        #1;
        in_valid = v;
        Si       = si;
        PB       = pb;
        PC       = pc;
        imm12_I  = ii;
        imm12_S  = is;
        imm20    = u;
        if (v) q.push_back('{expv, cyc + 1});
    endtask

    // Monitor: pops on every out_valid, otherwise N must hold the last result.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                check("out_valid_expected", 32'(q.size() != 0), 32'd1);
                if (q.size() != 0) begin
                    exp_t e;
                    e = q.pop_front();
                    check("N_value", N, e.data);
                    check("latency", 32'(cyc), 32'(e.cyc));
                    hold_val = e.data;
                end
            end else begin
                check("N_hold", N, hold_val);
            end
        end
    end

    localparam logic [31:0] C_PB  = 32'h0431FFEA;
    localparam logic [31:0] C_PC  = 32'hC431FFEA;
    localparam logic [11:0] C_II  = 12'hC0C;
    localparam logic [11:0] C_IS  = 12'h70F;
    localparam logic [19:0] C_U   = 20'hEC44F;

    logic [31:0] sweep_exp [8];

    initial begin
        sweep_exp[0] = 32'h0431FFEA;
        sweep_exp[1] = 32'hFFFFFC0C;
        sweep_exp[2] = 32'h0000070F;
        sweep_exp[3] = 32'hEC44F000;
        sweep_exp[4] = 32'hC431FFEA;
        sweep_exp[5] = 32'h0000000C;
`ifdef SOH_AUIPC_EN
        sweep_exp[6] = 32'hB076EFEA;
`else
        sweep_exp[6] = 32'h00000000;
`endif
        sweep_exp[7] = 32'h00000000;

        tests    = 0;
        fails    = 0;
        hold_val = 32'h0;
        rst_n    = 1'b1;
        in_valid = 1'b0;
        Si       = 3'd0;
        PB       = 32'h0;
        PC       = 32'h0;
        imm12_I  = 12'h0;
        imm12_S  = 12'h0;
        imm20    = 20'h0;
        #1;
        rst_n = 1'b0;
        #1;
        check("reset_N", N, 32'h0);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++)
            drive(1'b1, 3'(i), C_PB, C_PC, C_II, C_IS, C_U, sweep_exp[i]);

        drive(1'b1, 3'd1, C_PB, C_PC, 12'h800, C_IS, C_U, 32'hFFFFF800);
        drive(1'b1, 3'd1, C_PB, C_PC, 12'h7FF, C_IS, C_U, 32'h000007FF);

        drive(1'b1, 3'd0, C_PB, C_PC, C_II, C_IS, C_U, 32'h0431FFEA);
        drive(1'b0, 3'd0, 32'h12345678, C_PC, C_II, C_IS, C_U, 32'h0);
        drive(1'b0, 3'd0, 32'hDEADBEEF, C_PC, C_II, C_IS, C_U, 32'h0);

`ifdef SOH_AUIPC_EN
        drive(1'b1, 3'd6, C_PB, 32'hFFFFF000, C_II, C_IS, 20'h00001, 32'h00000000);
`endif

        // Reset lands between edges while a valid beat is pending.
        drive(1'b1, 3'd0, C_PB, C_PC, C_II, C_IS, C_U, 32'h0431FFEA);
        drive(1'b1, 3'd3, C_PB, C_PC, C_II, C_IS, C_U, 32'hEC44F000);
        #2;
        rst_n = 1'b0;
        q.delete();
        hold_val = 32'h0;
        #1;
        check("midreset_N", N, 32'h0);
        check("midreset_out_valid", 32'(out_valid), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("inreset_N", N, 32'h0);
        check("inreset_out_valid", 32'(out_valid), 32'd0);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        drive(1'b0, 3'd4, C_PB, C_PC, C_II, C_IS, C_U, 32'h0);
        drive(1'b1, 3'd4, C_PB, C_PC, C_II, C_IS, C_U, 32'hC431FFEA);

        for (int i = 0; i < 300; i++) begin
            logic        v;
            logic [2:0]  si;
            logic [31:0] pb, pc;
            logic [11:0] ii, is;
            logic [19:0] u;
            v  = ($urandom_range(3) != 0);
            si = 3'($urandom_range(7));
            pb = $urandom;
            pc = $urandom;
            ii = 12'($urandom);
            is = 12'($urandom);
            u  = 20'($urandom);
            drive(v, si, pb, pc, ii, is, u, model(si, pb, pc, ii, is, u));
        end

        for (int i = 0; i < 3; i++)
            drive(1'b0, 3'd0, 32'h0, 32'h0, 12'h0, 12'h0, 20'h0, 32'h0);
        check("queue_drained", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
